uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 73 +++++++
 rtl/uart_tx_frame.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes,
// transmit state encoding and the clocks-per-bit calculation.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous write FIFO for the UART transmitter; registered full/empty/level,
// writes while full are dropped and pointers wrap modulo DEPTH.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [LW-1:0]    level_d;

  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    level_d = level;
    if (push_ok && !pop_ok) begin
      level_d = level + LW'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level - LW'(1);
    end else begin
      level_d = level;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_d;
      full  <= (level_d == LW'(DEPTH));
      empty <= (level_d == '0);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: write FIFO feeding a start/data/parity/stop
// framer; back-to-back frames are sent with no idle gap.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_50M,
  input  logic                          rst,
  input  logic                          write_en,
  input  logic [DATA_BITS-1:0]          write_data,
  output logic                          uart_txd,
  output logic                          busy,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS + 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_frame: clocks per bit must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state;
  tx_state_t            next_state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] pop_data;
  logic                 par_bit;
  logic                 pop;
  logic                 fifo_empty;
  logic                 bit_end;
  logic                 last_data;
  logic                 last_stop;
  logic                 txd_d;

  assign bit_end   = (baud_cnt == CW'(DIV - 1));
  assign last_data = (bit_cnt == BW'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_50M),
    .rst       (rst),
    .push      (write_en),
    .push_data (write_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = fifo_empty ? IDLE : START;
      START:   next_state = bit_end ? DATA : START;
      DATA: begin
        if (bit_end && last_data) begin
          next_state = (PARITY != PARITY_NONE) ? PAR : STOP;
        end else begin
          next_state = DATA;
        end
      end
      PAR:     next_state = bit_end ? STOP : PAR;
      STOP: begin
        if (bit_end && last_stop) begin
          next_state = fifo_empty ? IDLE : START;
        end else begin
          next_state = STOP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The line register is loaded from the next state so the start bit appears on the pop edge.
  always_comb begin
    pop = ((state == IDLE) && !fifo_empty) ||
          ((state == STOP) && bit_end && last_stop && !fifo_empty);
    if (pop) begin
      shift_d = pop_data;
    end else if ((state == DATA) && bit_end) begin
      shift_d = shift >> 1;
    end else begin
      shift_d = shift;
    end
    case (next_state)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PAR:     txd_d = par_bit;
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      shift <= shift_d;
      if (pop) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
        par_bit  <= (^pop_data) ^ (PARITY == PARITY_ODD);
      end else if (state != IDLE) begin
        if (bit_end) begin
          baud_cnt <= '0;
          bit_cnt  <= (next_state != state) ? '0 : bit_cnt + BW'(1);
        end else begin
          baud_cnt <= baud_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      uart_txd <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      uart_txd <= txd_d;
      busy     <= (next_state != IDLE) || (write_en && !full);
      overflow <= overflow | (write_en & full);
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Three transmitter configurations driven with directed and random writes,
// compared every clock against a queue-and-timeline model of the line.
module tb_uart_tx_frame;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUDS [3] = '{100_000, 300_000, 250_000};
  localparam int NB    [3] = '{8, 7, 9};
  localparam int PARM  [3] = '{0, 2, 1};
  localparam int STP   [3] = '{1, 2, 1};
  localparam int DEP   [3] = '{4, 4, 2};

  logic       clk;
  logic [2:0] rst;
  logic [2:0] we;
  logic [8:0] wdat [3];
  logic [2:0] txd, busy, full, ovf;
  logic [2:0] lvl0, lvl1;
  logic [1:0] lvl2;

  int checks;
  int failures;

  // model state per instance
  int         m_div  [3];
  int         m_cnt  [3];
  int         m_head [3];
  int         m_act  [3];
  int         m_pos  [3];
  int         m_len  [3];
  int         m_ovf  [3];
  logic [8:0] m_mem  [3][4];
  bit         m_fb   [3][16];

  uart_tx_frame #(.CLK_FREQ(CLK_HZ), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk_50M(clk), .rst(rst[0]), .write_en(we[0]), .write_data(wdat[0][7:0]),
    .uart_txd(txd[0]), .busy(busy[0]), .full(full[0]), .overflow(ovf[0]), .fifo_level(lvl0));

  uart_tx_frame #(.CLK_FREQ(CLK_HZ), .BAUD(300_000), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .clk_50M(clk), .rst(rst[1]), .write_en(we[1]), .write_data(wdat[1][6:0]),
    .uart_txd(txd[1]), .busy(busy[1]), .full(full[1]), .overflow(ovf[1]), .fifo_level(lvl1));

  uart_tx_frame #(.CLK_FREQ(CLK_HZ), .BAUD(250_000), .DATA_BITS(9), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(2)) dut2 (
    .clk_50M(clk), .rst(rst[2]), .write_en(we[2]), .write_data(wdat[2]),
    .uart_txd(txd[2]), .busy(busy[2]), .full(full[2]), .overflow(ovf[2]), .fifo_level(lvl2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] word_mask(input int i);
    return 9'((1 << NB[i]) - 1);
  endfunction

  // One clock edge of the reference: finish/advance the frame, pop, then accept the write.
  task automatic model_step(input int i);
    bit         full_pre;
    logic [8:0] w;
    int         k;
    bit         p;
    if (rst[i]) begin
      m_cnt[i] = 0; m_head[i] = 0; m_act[i] = 0; m_pos[i] = 0; m_ovf[i] = 0;
    end else begin
      full_pre = (m_cnt[i] == DEP[i]);
      if (m_act[i] != 0) begin
        if (m_pos[i] == m_len[i] - 1) m_act[i] = 0;
        else m_pos[i]++;
      end
      if (m_act[i] == 0 && m_cnt[i] > 0) begin
        w = m_mem[i][m_head[i]];
        m_head[i] = (m_head[i] + 1) % DEP[i];
        m_cnt[i]--;
        m_fb[i][0] = 1'b0;
        for (int b = 0; b < NB[i]; b++) m_fb[i][1 + b] = w[b];
        k = 1 + NB[i];
        if (PARM[i] != 0) begin
          p = ^w;
          if (PARM[i] == 1) p = ~p;
          m_fb[i][k] = p;
          k++;
        end
        for (int s = 0; s < STP[i]; s++) begin
          m_fb[i][k] = 1'b1;
          k++;
        end
        m_len[i] = k * m_div[i];
        m_act[i] = 1;
        m_pos[i] = 0;
      end
      if (we[i]) begin
        if (full_pre) begin
          m_ovf[i] = 1;
        end else begin
          m_mem[i][(m_head[i] + m_cnt[i]) % DEP[i]] = wdat[i];
          m_cnt[i]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    int exp_txd;
    int got_lvl;
    for (int i = 0; i < 3; i++) begin
      exp_txd = (m_act[i] != 0) ? int'(m_fb[i][m_pos[i] / m_div[i]]) : 1;
      got_lvl = (i == 0) ? int'(lvl0) : (i == 1) ? int'(lvl1) : int'(lvl2);
      check_eq($sformatf("txd%0d", i), int'(txd[i]), exp_txd);
      check_eq($sformatf("busy%0d", i), int'(busy[i]),
               ((m_act[i] != 0) || (m_cnt[i] > 0)) ? 1 : 0);
      check_eq($sformatf("full%0d", i), int'(full[i]), (m_cnt[i] == DEP[i]) ? 1 : 0);
      check_eq($sformatf("level%0d", i), got_lvl, m_cnt[i]);
      check_eq($sformatf("overflow%0d", i), int'(ovf[i]), m_ovf[i]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    compare_all();
  endtask

  task automatic push_word(input int i, input logic [8:0] w);
    we[i]   = 1'b1;
    wdat[i] = w & word_mask(i);
    cycle();
    we[i]   = 1'b0;
  endtask

  int rates [6] = '{5, 30, 90, 100, 15, 60};

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 3; i++) begin
      m_div[i] = (CLK_HZ + BAUDS[i] / 2) / BAUDS[i];
      m_cnt[i] = 0; m_head[i] = 0; m_act[i] = 0; m_pos[i] = 0; m_len[i] = 0; m_ovf[i] = 0;
      wdat[i] = 9'd0;
    end
    rst = 3'b111;
    we  = 3'b000;
    repeat (3) cycle();
    rst = 3'b000;

    // single frames: 0xA5 8N1, 0x07 even/2 stop, 0x07 odd
    we = 3'b111;
    wdat[0] = 9'h0A5; wdat[1] = 9'h007; wdat[2] = 9'h007;
    cycle();
    we = 3'b000;
    repeat (150) cycle();

    // reset mid-DATA with two words queued, then a clean frame
    push_word(0, 9'h03C);
    push_word(0, 9'h011);
    push_word(0, 9'h022);
    repeat (30) cycle();
    rst[0] = 1'b1;
    cycle();
    rst[0] = 1'b0;
    push_word(0, 9'h05A);
    repeat (120) cycle();

    // consecutive writes fill the FIFO, the extra 0x55 overflows
    push_word(1, 9'h011);
    push_word(1, 9'h022);
    push_word(1, 9'h033);
    push_word(1, 9'h044);
    push_word(1, 9'h066);
    push_word(1, 9'h055);
    push_word(2, 9'h1F0);
    push_word(2, 9'h00F);
    push_word(2, 9'h155);
    repeat (400) cycle();

    // random traffic at several write rates with rare resets
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 1200; c++) begin
        for (int i = 0; i < 3; i++) begin
          we[i]   = ($urandom_range(0, 99) < rates[ph]);
          wdat[i] = 9'($urandom) & word_mask(i);
          rst[i]  = ($urandom_range(0, 2999) == 0);
        end
        cycle();
        if (failures > 40) break;
      end
      if (failures > 40) break;
    end

    we  = 3'b000;
    rst = 3'b000;
    if (failures <= 40) repeat (700) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
